// File: rtl/fmeter_pkg.sv
// Shared types, default widths and the saturating increment for the ring-oscillator frequency meter.
package fmeter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_t;

  localparam int DEF_GATE_W      = 16;
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_SYNC_STAGES = 2;

  // Returns {ovf, cnt}; the counter sticks at maxVal and ovf is raised as soon as maxVal is reached.
  function automatic logic [32:0] sat_inc(input logic [31:0] cnt, input logic ovf,
                                          input logic [31:0] maxVal);
    if (cnt >= maxVal - 32'd1) begin
      return {1'b1, maxVal};
    end
    return {ovf, cnt + 32'd1};
  endfunction

endpackage

// File: rtl/fmeter_sync.sv
// Synchronizer chain for the asynchronous oscillator input plus rising-edge detector.
module fmeter_sync
  import fmeter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Gated frequency counter for the ring oscillator: counts osc_in rising edges over gate_cycles clocks.
// Define FMETER_CONT_EN for continuous back-to-back measurement after the first start.
module ringosc_freq_meter
  import fmeter_pkg::*;
#(
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  input  logic [1:0]        byte_sel,
  output logic [7:0]        byte_out
);

  // Edge and result counters are kept 32 bits wide but never exceed CNT_MAX, so upper bits stay 0.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gateLen_q, gateLen_d;
  logic [GATE_W-1:0] winCnt_q, winCnt_d;
  logic [31:0]       edgeCnt_q, edgeCnt_d;
  logic              ovfInt_q, ovfInt_d;
  logic [31:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              rise;
  logic [32:0]       incRes;

  fmeter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .osc_i (osc_in),
    .rise_o(rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gateLen_q <= '0;
      winCnt_q  <= '0;
      edgeCnt_q <= '0;
      ovfInt_q  <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gateLen_q <= gateLen_d;
      winCnt_q  <= winCnt_d;
      edgeCnt_q <= edgeCnt_d;
      ovfInt_q  <= ovfInt_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  // The result is loaded on entry to DONE so count/ovf change together with the done pulse.
  always_comb begin
    state_d   = state_q;
    gateLen_d = gateLen_q;
    winCnt_d  = winCnt_q;
    edgeCnt_d = edgeCnt_q;
    ovfInt_d  = ovfInt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    incRes    = sat_inc(edgeCnt_q, ovfInt_q, CNT_MAX);
    case (state_q)
      IDLE: begin
        if (start) begin
          gateLen_d = gate_cycles;
          state_d   = ARM;
        end
      end
      ARM: begin
        edgeCnt_d = '0;
        ovfInt_d  = 1'b0;
        winCnt_d  = gateLen_q;
        if (gateLen_q == '0) begin
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (rise) begin
          edgeCnt_d = incRes[31:0];
          ovfInt_d  = incRes[32];
        end
        winCnt_d = winCnt_q - GATE_W'(1);
        if (winCnt_q == GATE_W'(1)) begin
          result_d = edgeCnt_d;
          ovf_d    = ovfInt_d;
          state_d  = DONE;
        end
      end
      DONE: begin
`ifdef FMETER_CONT_EN
        state_d = ARM;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == ARM) || (state_q == GATE);
  assign done     = (state_q == DONE);
  assign count    = result_q[CNT_W-1:0];
  assign ovf      = ovf_q;
  assign byte_out = result_q[{byte_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Self-checking bench for ringosc_freq_meter: scoreboard of expected results popped on each done.
// Build with FMETER_CONT_EN defined to exercise continuous mode.
module tb_ringosc_freq_meter;

  typedef struct {
    logic [23:0] cnt;
    logic        ov;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        osc = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gateCycles = '0;
  logic [1:0]  byteSel = '0;
  logic        busy, done, ovf;
  logic [23:0] count;
  logic [7:0]  byteOut;

  logic        start8 = 1'b0;
  logic [15:0] gate8 = '0;
  logic [1:0]  byteSel8 = '0;
  logic        busy8, done8, ovf8;
  logic [7:0]  count8, byteOut8;

  int   oscHalf = 4;
  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t expQ[$];

  ringosc_freq_meter dut (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .gate_cycles(gateCycles),
    .busy(busy), .done(done), .count(count), .ovf(ovf), .byte_sel(byteSel), .byte_out(byteOut)
  );

  ringosc_freq_meter #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start8), .gate_cycles(gate8),
    .busy(busy8), .done(done8), .count(count8), .ovf(ovf8), .byte_sel(byteSel8), .byte_out(byteOut8)
  );

  always #5 clk = ~clk;

  // Oscillator toggles on clk falling edges every oscHalf cycles, giving a period of 2*oscHalf clocks.
  initial begin
    forever begin
      repeat (oscHalf) @(negedge clk);
      osc = ~osc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runMeas(input bit use8, input int g, input int budget, output int lat,
                         output int busyCyc, output bit seen, output logic [23:0] cntObs,
                         output logic ovfObs);
    lat = 0; busyCyc = 0; seen = 1'b0; cntObs = '0; ovfObs = 1'b0;
    if (use8) begin gate8 = 16'(g); start8 = 1'b1; end
    else begin gateCycles = 16'(g); start = 1'b1; end
    for (int i = 1; i <= budget; i++) begin
      tick();
      start = 1'b0; start8 = 1'b0;
      if (use8 ? busy8 : busy) busyCyc++;
      if (use8 ? done8 : done) begin
        seen = 1'b1; lat = i;
        cntObs = use8 ? {16'd0, count8} : count;
        ovfObs = use8 ? ovf8 : ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
    nCompared++; if (count !== 24'd0) begin nMismatched++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    nCompared++; if (ovf !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    nCompared++; if (byteOut !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_byte got %0d want 0", byteOut); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_measurement();
    int lat, bc; bit seen; logic [23:0] c; logic o; exp_t e;
    oscHalf = 4;
    expQ.push_back('{cnt: 24'd100, ov: 1'b0, lat: 802});
    runMeas(1'b0, 800, 900, lat, bc, seen, c, o);
    e = expQ.pop_front();
    nCompared++; if (seen !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_timeout got %b want 1", seen); end
    nCompared++; if (lat != e.lat) begin nMismatched++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, e.lat); end
    nCompared++; if (c !== e.cnt) begin nMismatched++; $display("[TB] FAIL basic_count got %0d want %0d", c, e.cnt); end
    nCompared++; if (o !== e.ov) begin nMismatched++; $display("[TB] FAIL basic_ovf got %b want %b", o, e.ov); end
    byteSel = 2'd0; #1;
    nCompared++; if (byteOut !== e.cnt[7:0]) begin nMismatched++; $display("[TB] FAIL basic_byte0 got %0d want %0d", byteOut, e.cnt[7:0]); end
    byteSel = 2'd3; #1;
    nCompared++; if (byteOut !== 8'd0) begin nMismatched++; $display("[TB] FAIL basic_byte3 got %0d want 0", byteOut); end
    byteSel = 2'd0;
    tick();
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
    nCompared++; if (count !== e.cnt) begin nMismatched++; $display("[TB] FAIL basic_count_hold got %0d want %0d", count, e.cnt); end
  endtask

  task automatic test_zero_gate();
    int lat, bc; bit seen; logic [23:0] c; logic o; exp_t e;
    expQ.push_back('{cnt: 24'd0, ov: 1'b0, lat: 2});
    runMeas(1'b0, 0, 20, lat, bc, seen, c, o);
    e = expQ.pop_front();
    nCompared++; if (lat != e.lat) begin nMismatched++; $display("[TB] FAIL zero_latency got %0d want %0d", lat, e.lat); end
    nCompared++; if (c !== e.cnt) begin nMismatched++; $display("[TB] FAIL zero_count got %0d want %0d", c, e.cnt); end
    nCompared++; if (bc != 1) begin nMismatched++; $display("[TB] FAIL zero_busy_cycles got %0d want 1", bc); end
    tick();
  endtask

  task automatic test_saturation();
    int lat, bc; bit seen; logic [23:0] c; logic o; exp_t e;
    oscHalf = 2;
    expQ.push_back('{cnt: 24'd255, ov: 1'b1, lat: 2002});
    runMeas(1'b1, 2000, 2100, lat, bc, seen, c, o);
    e = expQ.pop_front();
    nCompared++; if (lat != e.lat) begin nMismatched++; $display("[TB] FAIL sat_latency got %0d want %0d", lat, e.lat); end
    nCompared++; if (c !== e.cnt) begin nMismatched++; $display("[TB] FAIL sat_count got %0d want %0d", c, e.cnt); end
    nCompared++; if (o !== e.ov) begin nMismatched++; $display("[TB] FAIL sat_ovf got %b want %b", o, e.ov); end
    byteSel8 = 2'd0; #1;
    nCompared++; if (byteOut8 !== 8'hFF) begin nMismatched++; $display("[TB] FAIL sat_byte0 got %h want ff", byteOut8); end
    byteSel8 = 2'd1; #1;
    nCompared++; if (byteOut8 !== 8'h00) begin nMismatched++; $display("[TB] FAIL sat_byte1 got %h want 00", byteOut8); end
    byteSel8 = 2'd0;
    tick();
  endtask

  task automatic test_back_to_back();
    int nDone, lastDone, spacing; exp_t e;
    oscHalf = 4;
    // A second start pulse during GATE must not start another measurement.
    expQ.push_back('{cnt: 24'd3, ov: 1'b0, lat: 26});
    gateCycles = 16'd24; start = 1'b1; nDone = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      start = (i == 10);
      if (done) begin
        nDone++;
        if (nDone == 1) begin
          e = expQ.pop_front();
          nCompared++; if (i != e.lat) begin nMismatched++; $display("[TB] FAIL ign_latency got %0d want %0d", i, e.lat); end
          nCompared++; if (count !== e.cnt) begin nMismatched++; $display("[TB] FAIL ign_count got %0d want %0d", count, e.cnt); end
        end
      end
    end
    nCompared++; if (nDone != 1) begin nMismatched++; $display("[TB] FAIL ign_done_pulses got %0d want 1", nDone); end
    // Start held high: one IDLE cycle between measurements, so done every G+3 clocks.
    for (int k = 0; k < 3; k++) expQ.push_back('{cnt: 24'd3, ov: 1'b0, lat: 27});
    start = 1'b1; nDone = 0; lastDone = 0;
    for (int i = 1; i <= 200 && nDone < 3; i++) begin
      tick();
      if (done) begin
        nDone++;
        e = expQ.pop_front();
        nCompared++; if (count !== e.cnt) begin nMismatched++; $display("[TB] FAIL b2b_count got %0d want %0d", count, e.cnt); end
        if (nDone > 1) begin
          spacing = i - lastDone;
          nCompared++; if (spacing != e.lat) begin nMismatched++; $display("[TB] FAIL b2b_spacing got %0d want %0d", spacing, e.lat); end
        end
        lastDone = i;
      end
    end
    start = 1'b0;
    nCompared++; if (nDone != 3) begin nMismatched++; $display("[TB] FAIL b2b_timeout got %0d want 3", nDone); end
    expQ.delete();
    repeat (3) tick();
  endtask

  task automatic test_reset_abort();
    int nDone;
    gateCycles = 16'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (50) tick();
    rst = 1'b1;
    tick();
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    nCompared++; if (count !== 24'd0) begin nMismatched++; $display("[TB] FAIL abort_count got %0d want 0", count); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_done got %b want 0", done); end
    rst = 1'b0; nDone = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (done) nDone++;
    end
    nCompared++; if (nDone != 0) begin nMismatched++; $display("[TB] FAIL abort_no_done got %0d want 0", nDone); end
  endtask

  task automatic test_continuous();
    int nDone, lastDone, spacing; exp_t e;
    oscHalf = 5;
    for (int k = 0; k < 4; k++) expQ.push_back('{cnt: 24'd10, ov: 1'b0, lat: 102});
    gateCycles = 16'd100; start = 1'b1; nDone = 0; lastDone = 0;
    for (int i = 1; i <= 600 && nDone < 4; i++) begin
      tick();
      start = (i == 150);
      if (done) begin
        nDone++;
        e = expQ.pop_front();
        spacing = i - lastDone;
        nCompared++; if (spacing != e.lat) begin nMismatched++; $display("[TB] FAIL cont_spacing got %0d want %0d", spacing, e.lat); end
        nCompared++; if (count !== e.cnt) begin nMismatched++; $display("[TB] FAIL cont_count got %0d want %0d", count, e.cnt); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL cont_busy_done got %b want 0", busy); end
        lastDone = i;
      end
    end
    start = 1'b0;
    nCompared++; if (nDone != 4) begin nMismatched++; $display("[TB] FAIL cont_timeout got %0d want 4", nDone); end
  endtask

  initial begin
    test_reset();
`ifdef FMETER_CONT_EN
    test_saturation();
    test_continuous();
`else
    test_measurement();
    test_zero_gate();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
